imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
Boot-time controller that fills the CPU's instruction memory from a byte stream before the core runs. It sits between an external byte source (UART receiver or testbench) and the instruction memory write port. It holds the single-cycle core in reset while loading, then releases it so fetch starts at PC=0 with the new program. It also owns the only write path into instruction memory. CPU fetch stays read-only.

Parameters:
DEPTH, 64, number of 32-bit words in instruction memory
ADDR_W, 6, word-address width (log2 DEPTH)
LEN_W, 7, width of word-count input (must hold DEPTH)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse: begin a load of len words
len  in  LEN_W  number of words to load; sampled only when start is accepted
byte_valid  in  1  byte_data holds a valid byte
byte_data  in  8  program byte, little-endian within each word
byte_ready  out  1  loader accepts byte this cycle
mem_we  out  1  instruction memory write enable
mem_waddr  out  ADDR_W  word address of write
mem_wdata  out  32  word to write
cpu_reset  out  1  active-high hold for the CPU core
busy  out  1  load in progress (RECV or WRITE)
done  out  1  last load completed successfully (level)
err  out  1  last start rejected (level)

Behaviour:
- Reset values, with rst_n low and asynchronous: state=IDLE, byte_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, cpu_reset=1, busy=0, done=0, err=0, byte counter=0, word index=0. Asserting rst_n mid-load aborts the load immediately. Partially written memory is left as is.
- States: IDLE, RECV, WRITE, DONE. All outputs are registered except byte_ready, which is 1 exactly when state==RECV.
- IDLE/DONE + start:
  - If len==0 or len>DEPTH: err<=1, done<=0, state unchanged. cpu_reset keeps its value.
  - Otherwise: latch len; word index=0; byte counter=0; err<=0; done<=0; cpu_reset<=1; state<=RECV.
- start in RECV or WRITE is ignored. It has no effect on any register.
- RECV: on byte_valid && byte_ready, byte k (k=0..3) goes into bits [8k+7:8k] of the assembly register, and k increments.
  - On acceptance of byte 3: state<=WRITE next cycle, and k wraps to 0.
  - byte_valid low: hold, with no timeout.
- WRITE: exactly one cycle with mem_we=1, mem_waddr=word index, mem_wdata=assembled word. byte_ready=0 in this cycle.
  - If word index==len-1: state<=DONE, done<=1, cpu_reset<=0. cpu_reset drops on the same edge that ends the write, so the core's first fetch sees the final contents.
  - Otherwise: word index increments and state<=RECV.
- Write throughput: at most one word per 5 cycles (4 accept cycles + 1 write cycle).
- DONE: cpu_reset=0, done=1, busy=0. A valid start re-enters RECV and re-asserts cpu_reset on the next edge.
- IDLE after reset: cpu_reset=1. The core stays held until the first successful load.
- busy=1 iff state is RECV or WRITE.
- mem_we is never asserted outside WRITE. mem_waddr never exceeds len-1.
- Bytes offered while byte_ready=0 are not consumed. The source must hold them.

Test Plan:
- Reset then start, len=2. Feed bytes 0F,00,4F,E0,05,20,80,E2 back-to-back.
  - Required: writes at cycle 5 (addr0=E04F000F) and cycle 10 (addr1=E2802005), relative to first accept.
  - Required: done=1 and cpu_reset=0 after second write; busy=0.
- Start with len=0, then len=65.
  - Required: err=1, no mem_we, state IDLE, cpu_reset stays 1.
  - Then a valid start with len=1 clears err.
- len=1 with byte_valid toggled 1,0,0,1,1,0,1.
  - Required: only 4 bytes consumed.
  - Required: single write at addr0 with correct packing; byte_ready=0 during the WRITE cycle.
- Mid-load, after 5 of 8 bytes with len=2, pulse start with len=3.
  - Required: the start is ignored; load completes with 2 words and done=1.
- Mid-load, assert rst_n low for 1 cycle.
  - Required: all outputs return to reset values asynchronously; a subsequent len=1 load writes addr0.
- After done, issue start len=64 and stream 256 bytes.
  - Required: cpu_reset=1 on the next edge; 64 writes to addr 0..63 in order.
  - Required: done and cpu_reset low only after the write to addr 63.

Source files
------------

// File: rtl/imem_boot_loader_if.sv
// Loader-side bundle: start/len control, byte-stream handshake, imem write port, CPU hold and status.
// The master modport drives the loader's inputs (byte source / boot controller); slave is the loader itself.
interface imem_boot_loader_if #(
    parameter int ADDR_W = 6,
    parameter int LEN_W  = 7
);
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, len, byte_valid, byte_data,
        input  byte_ready, mem_we, mem_waddr, mem_wdata, cpu_reset, busy, done, err
    );

    modport slave (
        input  start, len, byte_valid, byte_data,
        output byte_ready, mem_we, mem_waddr, mem_wdata, cpu_reset, busy, done, err
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Packs a little-endian byte stream into 32-bit imem words, holding the CPU in reset until the last word lands.
// One word per 5 cycles (4 accepts + 1 write); byte_ready drops during the write, the source must hold its byte.
module imem_boot_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int LEN_W  = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    imem_boot_loader_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RECV  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [1:0]        byte_cnt;
    logic [ADDR_W-1:0] word_idx;
    logic [LEN_W-1:0]  len_q;
    logic [23:0]       asm_lo;

    logic start_ok;
    logic accept;
    logic last_word;

    assign start_ok  = (bus.len != '0) && (bus.len <= LEN_W'(DEPTH));
    assign accept    = bus.byte_valid && (state == S_RECV);
    assign last_word = (LEN_W'(word_idx) == (len_q - LEN_W'(1)));

    assign bus.byte_ready = (state == S_RECV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            byte_cnt      <= '0;
            word_idx      <= '0;
            len_q         <= '0;
            asm_lo        <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_waddr <= '0;
            bus.mem_wdata <= '0;
            bus.cpu_reset <= 1'b1;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        bus.done <= 1'b0;
                        if (start_ok) begin
                            len_q         <= bus.len;
                            word_idx      <= '0;
                            byte_cnt      <= '0;
                            bus.err       <= 1'b0;
                            bus.cpu_reset <= 1'b1;
                            bus.busy      <= 1'b1;
                            state         <= S_RECV;
                        end else begin
                            // Rejected start leaves the state and the CPU hold untouched.
                            bus.err <= 1'b1;
                        end
                    end
                end

                S_RECV: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0:    asm_lo[7:0]   <= bus.byte_data;
                            2'd1:    asm_lo[15:8]  <= bus.byte_data;
                            2'd2:    asm_lo[23:16] <= bus.byte_data;
                            default: begin
                                // Top byte goes straight to the write register, so the word is ready in WRITE.
                                bus.mem_we    <= 1'b1;
                                bus.mem_waddr <= word_idx;
                                bus.mem_wdata <= {bus.byte_data, asm_lo};
                                state         <= S_WRITE;
                            end
                        endcase
                    end
                end

                S_WRITE: begin
                    bus.mem_we <= 1'b0;
                    if (last_word) begin
                        // Release the core on the edge that completes the final write.
                        bus.done      <= 1'b1;
                        bus.cpu_reset <= 1'b0;
                        bus.busy      <= 1'b0;
                        state         <= S_DONE;
                    end else begin
                        word_idx <= word_idx + ADDR_W'(1);
                        state    <= S_RECV;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    a_we_only_in_write: assert property (@(posedge clk) disable iff (!rst_n)
        bus.mem_we |-> (state == S_WRITE));
    a_waddr_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        bus.mem_we |-> (LEN_W'(bus.mem_waddr) < len_q));
    a_busy_matches_state: assert property (@(posedge clk) disable iff (!rst_n)
        bus.busy == ((state == S_RECV) || (state == S_WRITE)));

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: vector table for the basic load/reject/stall cases, then
// hand-written sequences for ignored start, mid-load reset and a full-depth load.
module tb_imem_boot_loader;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;
    localparam int LEN_W  = 7;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    imem_boot_loader_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    imem_boot_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int n_accept = 0;
    logic [ADDR_W-1:0] wr_addr [$];
    logic [31:0]       wr_data [$];

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.byte_valid && bus.byte_ready) n_accept++;
            if (bus.mem_we) begin
                wr_addr.push_back(bus.mem_waddr);
                wr_data.push_back(bus.mem_wdata);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // {byte_ready, mem_we, mem_waddr, mem_wdata, cpu_reset, busy, done, err}
    function automatic logic [43:0] outs(input logic r, input logic we, input logic [5:0] a,
                                         input logic [31:0] d, input logic c, input logic b,
                                         input logic dn, input logic e);
        return {r, we, a, d, c, b, dn, e};
    endfunction

    function automatic logic [43:0] dut_outs();
        return {bus.byte_ready, bus.mem_we, bus.mem_waddr, bus.mem_wdata,
                bus.cpu_reset, bus.busy, bus.done, bus.err};
    endfunction

    function automatic logic [31:0] word_e(input int i);
        logic [7:0] a;
        a = i[7:0];
        return {a, 8'hC3, a ^ 8'h5A, ~a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string name);
        bus.start      = 1'b0;
        bus.len        = '0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;
        rst_n          = 1'b0;
        #1;
        chk(name, dut_outs(), outs(0, 0, 6'd0, 32'h0, 1, 0, 0, 0));
        tick();
        rst_n = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n              = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (!bus.byte_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            checks++;
            failures++;
            $display("FAIL byte_wait: byte_ready stayed %b for %0d cycles, required 1", bus.byte_ready, n);
        end else begin
            tick();
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
        bus.byte_valid = 1'b0;
    endtask

    typedef struct {
        logic             rst_first;
        logic             start;
        logic [LEN_W-1:0] len;
        logic             vld;
        logic [7:0]       dat;
        logic [43:0]      exp;
    } vec_t;

    vec_t vecs [$];

    task automatic addv(input logic r, input logic s, input logic [LEN_W-1:0] l,
                        input logic v, input logic [7:0] d, input logic [43:0] e);
        vec_t t;
        t.rst_first = r;
        t.start     = s;
        t.len       = l;
        t.vld       = v;
        t.dat       = d;
        t.exp       = e;
        vecs.push_back(t);
    endtask

    initial begin
        int early;
        int mism;
        int acc0;

        rst_n          = 1'b1;
        bus.start      = 1'b0;
        bus.len        = '0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;

        // Two-word load, back-to-back bytes; 05 is held through the WRITE cycle.
        addv(1, 1, 7'd2, 0, 8'h00, outs(1, 0, 6'd0, 32'h0,        1, 1, 0, 0));
        addv(0, 0, 7'd0, 1, 8'h0F, outs(1, 0, 6'd0, 32'h0,        1, 1, 0, 0));
        addv(0, 0, 7'd0, 1, 8'h00, outs(1, 0, 6'd0, 32'h0,        1, 1, 0, 0));
        addv(0, 0, 7'd0, 1, 8'h4F, outs(1, 0, 6'd0, 32'h0,        1, 1, 0, 0));
        addv(0, 0, 7'd0, 1, 8'hE0, outs(0, 1, 6'd0, 32'hE04F000F, 1, 1, 0, 0));
        addv(0, 0, 7'd0, 1, 8'h05, outs(1, 0, 6'd0, 32'hE04F000F, 1, 1, 0, 0));
        addv(0, 0, 7'd0, 1, 8'h05, outs(1, 0, 6'd0, 32'hE04F000F, 1, 1, 0, 0));
        addv(0, 0, 7'd0, 1, 8'h20, outs(1, 0, 6'd0, 32'hE04F000F, 1, 1, 0, 0));
        addv(0, 0, 7'd0, 1, 8'h80, outs(1, 0, 6'd0, 32'hE04F000F, 1, 1, 0, 0));
        addv(0, 0, 7'd0, 1, 8'hE2, outs(0, 1, 6'd1, 32'hE2802005, 1, 1, 0, 0));
        addv(0, 0, 7'd0, 0, 8'h00, outs(0, 0, 6'd1, 32'hE2802005, 0, 0, 1, 0));
        // Rejected lengths from IDLE, then len=1 with a gappy byte_valid.
        addv(1, 1, 7'd0,  0, 8'h00, outs(0, 0, 6'd0, 32'h0,        1, 0, 0, 1));
        addv(0, 1, 7'd65, 0, 8'h00, outs(0, 0, 6'd0, 32'h0,        1, 0, 0, 1));
        addv(0, 0, 7'd0,  0, 8'h00, outs(0, 0, 6'd0, 32'h0,        1, 0, 0, 1));
        addv(0, 1, 7'd1,  0, 8'h00, outs(1, 0, 6'd0, 32'h0,        1, 1, 0, 0));
        addv(0, 0, 7'd0,  1, 8'h11, outs(1, 0, 6'd0, 32'h0,        1, 1, 0, 0));
        addv(0, 0, 7'd0,  0, 8'hAA, outs(1, 0, 6'd0, 32'h0,        1, 1, 0, 0));
        addv(0, 0, 7'd0,  0, 8'hAA, outs(1, 0, 6'd0, 32'h0,        1, 1, 0, 0));
        addv(0, 0, 7'd0,  1, 8'h22, outs(1, 0, 6'd0, 32'h0,        1, 1, 0, 0));
        addv(0, 0, 7'd0,  1, 8'h33, outs(1, 0, 6'd0, 32'h0,        1, 1, 0, 0));
        addv(0, 0, 7'd0,  0, 8'hAA, outs(1, 0, 6'd0, 32'h0,        1, 1, 0, 0));
        addv(0, 0, 7'd0,  1, 8'h44, outs(0, 1, 6'd0, 32'h44332211, 1, 1, 0, 0));
        addv(0, 0, 7'd0,  1, 8'h55, outs(0, 0, 6'd0, 32'h44332211, 0, 0, 1, 0));
        addv(0, 0, 7'd0,  1, 8'h66, outs(0, 0, 6'd0, 32'h44332211, 0, 0, 1, 0));

        #2;
        foreach (vecs[i]) begin
            if (vecs[i].rst_first) do_reset($sformatf("reset_before_vec%0d", i));
            bus.start      = vecs[i].start;
            bus.len        = vecs[i].len;
            bus.byte_valid = vecs[i].vld;
            bus.byte_data  = vecs[i].dat;
            tick();
            chk($sformatf("vec%0d", i), dut_outs(), vecs[i].exp);
        end
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        chk("tbl_accepts", n_accept, 12);
        chk("tbl_writes", wr_addr.size(), 3);

        // Start pulse in the middle of a load must be ignored.
        do_reset("reset_ign");
        wr_addr.delete();
        wr_data.delete();
        bus.start = 1'b1;
        bus.len   = 7'd2;
        tick();
        bus.start = 1'b0;
        send_word(32'h1234_5678);
        send_byte(8'h9A);
        bus.byte_valid = 1'b0;
        bus.start      = 1'b1;
        bus.len        = 7'd3;
        tick();
        bus.start = 1'b0;
        bus.len   = '0;
        chk("ign_flags", {bus.busy, bus.err, bus.done, bus.cpu_reset}, 4'b1001);
        send_byte(8'hBC);
        send_byte(8'hDE);
        send_byte(8'hF0);
        bus.byte_valid = 1'b0;
        tick();
        chk("ign_done", {bus.done, bus.cpu_reset, bus.busy}, 3'b100);
        chk("ign_nwr", wr_addr.size(), 2);
        chk("ign_w0", (wr_addr.size() > 0) ? {wr_addr[0], wr_data[0]} : 38'h3F_FFFF_FFFF, {6'd0, 32'h1234_5678});
        chk("ign_w1", (wr_addr.size() > 1) ? {wr_addr[1], wr_data[1]} : 38'h3F_FFFF_FFFF, {6'd1, 32'hF0DE_BC9A});

        // Reset asserted partway through a word.
        bus.start = 1'b1;
        bus.len   = 7'd2;
        tick();
        bus.start = 1'b0;
        send_byte(8'h11);
        send_byte(8'h22);
        bus.byte_valid = 1'b0;
        do_reset("reset_midload");
        wr_addr.delete();
        wr_data.delete();
        bus.start = 1'b1;
        bus.len   = 7'd1;
        tick();
        bus.start = 1'b0;
        send_word(32'hCAFE_F00D);
        tick();
        chk("rst_nwr", wr_addr.size(), 1);
        chk("rst_w0", (wr_addr.size() > 0) ? {wr_addr[0], wr_data[0]} : 38'h3F_FFFF_FFFF, {6'd0, 32'hCAFE_F00D});
        chk("rst_done", {bus.done, bus.cpu_reset, bus.busy, bus.err}, 4'b1000);

        // Full-depth reload from DONE.
        wr_addr.delete();
        wr_data.delete();
        acc0      = n_accept;
        bus.start = 1'b1;
        bus.len   = 7'd64;
        tick();
        bus.start = 1'b0;
        chk("full_start", {bus.cpu_reset, bus.done, bus.busy}, 3'b101);
        early = 0;
        for (int i = 0; i < 64; i++) begin
            send_word(word_e(i));
            if (bus.done || !bus.cpu_reset || !bus.mem_we) early++;
        end
        chk("full_held", early, 0);
        tick();
        chk("full_done", {bus.done, bus.cpu_reset, bus.busy}, 3'b100);
        chk("full_accepts", n_accept - acc0, 256);
        chk("full_nwr", wr_addr.size(), 64);
        mism = 0;
        if (wr_addr.size() != 64) begin
            mism = 999;
        end else begin
            for (int i = 0; i < 64; i++)
                if (wr_addr[i] != ADDR_W'(i) || wr_data[i] !== word_e(i)) mism++;
        end
        chk("full_order", mism, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
